// File: rtl/ov7670_dvp_source.sv
// OV7670-style DVP transmitter: emits vsync, href and byte-serial RGB565 test
// patterns with the camera's frame timing, one byte per clk (pclk) cycle.
module ov7670_dvp_source #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int COL_W    = $clog2(LINE_LEN);
  localparam int LINE_W   = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int BAR_W    = H_ACTIVE / 8;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
  localparam logic [COL_W-1:0] HREF_END = COL_W'(2 * H_ACTIVE);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [1:0]         patSel_q, patSel_d;
  logic [15:0]        solid_q, solid_d;
  logic [15:0]        pixIdx_q, pixIdx_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [7:0]         pData_q, pData_d;
  logic               frameDone_q, frameDone_d;
  logic               busy_q, busy_d;
  logic [15:0]        frameCount_q, frameCount_d;

  logic               lineEnd;
  logic               enterFrame;
  logic [15:0]        xPos;
  logic [4:0]         xHi;
  logic [5:0]         yHi;
  logic [2:0]         bar;
  logic [15:0]        pix;

  // Next position first, then every output is derived from that position so
  // the registered outputs line up exactly with the counters they describe.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    line_d       = line_q;
    patSel_d     = patSel_q;
    solid_d      = solid_q;
    pixIdx_d     = pixIdx_q;
    enterFrame   = 1'b0;
    lineEnd      = (col_q == COL_LAST);

    if (state_q != IDLE) begin
      col_d  = lineEnd ? '0 : col_q + COL_W'(1);
      line_d = lineEnd ? line_q + LINE_W'(1) : line_q;
    end

    case (state_q)
      IDLE:   if (start) enterFrame = 1'b1;
      VSYNC:  if (lineEnd && line_q == LINE_W'(VSYNC_LINES - 1)) begin
                state_d = VBACK;
                line_d  = '0;
              end
      VBACK:  if (lineEnd && line_q == LINE_W'(V_BACK - 1)) begin
                state_d = ACTIVE;
                line_d  = '0;
              end
      ACTIVE: if (lineEnd && line_q == LINE_W'(V_ACTIVE - 1)) begin
                state_d = VFRONT;
                line_d  = '0;
              end
      VFRONT: if (lineEnd && line_q == LINE_W'(V_FRONT - 1)) begin
                line_d  = '0;
                if (start) enterFrame = 1'b1;
                else       state_d    = IDLE;
              end
      default: state_d = IDLE;
    endcase

    // Pattern controls are captured only here so mid-frame changes wait a frame.
    if (enterFrame) begin
      state_d  = VSYNC;
      col_d    = '0;
      line_d   = '0;
      patSel_d = pattern_sel;
      solid_d  = solid_rgb;
      pixIdx_d = '0;
    end

    xPos = 16'(col_d >> 1);
    xHi  = 5'(col_d >> 4);
    yHi  = 6'(line_d >> 2);
    bar  = 3'(xPos / 16'(BAR_W));

    case (patSel_q)
      2'd0: case (bar)
              3'd0:    pix = 16'hFFFF;
              3'd1:    pix = 16'hFFE0;
              3'd2:    pix = 16'h07FF;
              3'd3:    pix = 16'h07E0;
              3'd4:    pix = 16'hF81F;
              3'd5:    pix = 16'hF800;
              3'd6:    pix = 16'h001F;
              default: pix = 16'h0000;
            endcase
      2'd1:    pix = {xHi, yHi, xHi};
      2'd2:    pix = pixIdx_q;
      default: pix = solid_q;
    endcase

    vsync_d      = (state_d == VSYNC);
    href_d       = (state_d == ACTIVE) && (col_d < HREF_END);
    busy_d       = (state_d != IDLE);
    frameDone_d  = (state_d == VFRONT) && (col_d == COL_LAST) &&
                   (line_d == LINE_W'(V_FRONT - 1));
    frameCount_d = frameCount_q + {15'd0, frameDone_d};
    pData_d      = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;

    // The running index advances after the low byte of each pixel.
    if (href_d && col_d[0]) pixIdx_d = pixIdx_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      line_q       <= '0;
      patSel_q     <= '0;
      solid_q      <= '0;
      pixIdx_q     <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      pData_q      <= '0;
      frameDone_q  <= 1'b0;
      busy_q       <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      line_q       <= line_d;
      patSel_q     <= patSel_d;
      solid_q      <= solid_d;
      pixIdx_q     <= pixIdx_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      pData_q      <= pData_d;
      frameDone_q  <= frameDone_d;
      busy_q       <= busy_d;
      frameCount_q <= frameCount_d;
    end
  end

  assign vsync       = vsync_q;
  assign href        = href_q;
  assign p_data      = pData_q;
  assign frame_done  = frameDone_q;
  assign busy        = busy_q;
  assign frame_count = frameCount_q;

endmodule
